// File: rtl/tetris_pkg.sv
// Shared definitions for the board writer: default geometry, FSM encoding, row slicing.
package tetris_pkg;

  localparam int ROWS_DEF = 20;
  localparam int COLS_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    SCAN,
    FILL,
    COMMIT
  } state_t;

  // Row r occupies [row_msb -: cols]; row 0 is the top row, at the MSB end.
  function automatic int row_msb(input int r, input int rows, input int cols);
    return rows * cols - 1 - cols * r;
  endfunction

endpackage

// File: rtl/tetris_row_full.sv
// Combinational full-row detector: high when every cell of the row is occupied.
module tetris_row_full #(
  parameter int COLS = 10
) (
  input  logic [COLS-1:0] row,
  output logic            full
);

  assign full = &row;

endmodule

// File: rtl/tetris_board_writer.sv
// Locked-board owner: merges a piece, compacts cleared rows, commits the board atomically.
// Optional macro BOARD_TOPOUT_EN: a committed board with a non-empty top row ends the game.
module tetris_board_writer
  import tetris_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int LINES_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] piece_mask,
  input  logic                 lock_valid,
  output logic                 lock_ready,
  output logic [ROWS*COLS-1:0] board,
  output logic                 collide,
  output logic                 busy,
  output logic [4:0]           last_clear,
  output logic [LINES_W-1:0]   lines_cleared,
  output logic                 game_over
);

  localparam int IDX_W = $clog2(ROWS);
  localparam logic [IDX_W:0] TOP_IDX  = (IDX_W+1)'(ROWS - 1);
  localparam logic [IDX_W:0] ROWS_IDX = (IDX_W+1)'(ROWS);
  localparam logic [IDX_W:0] ONE_IDX  = (IDX_W+1)'(1);

  state_t          state, state_nxt;
  logic [COLS-1:0] work [ROWS];
  logic [IDX_W:0]  src, dst;
  logic [4:0]      cnt;
  logic [COLS-1:0] src_row;
  logic            src_full;
  logic            accept;
  logic            overlap;

  function automatic logic [LINES_W-1:0] sat_add(input logic [LINES_W-1:0] a,
                                                 input logic [4:0] b);
    logic [LINES_W:0] s;
    s = {1'b0, a} + (LINES_W+1)'(b);
    return s[LINES_W] ? '1 : s[LINES_W-1:0];
  endfunction

  assign src_row = (src < ROWS_IDX) ? work[src[IDX_W-1:0]] : '0;
  assign overlap = |(board & piece_mask);
  assign accept  = lock_valid & lock_ready;

  tetris_row_full #(.COLS(COLS)) u_row_full (
    .row  (src_row),
    .full (src_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    lock_ready = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        lock_ready = !game_over;
        if (lock_valid && !game_over) state_nxt = MERGE;
      end
      MERGE:  state_nxt = game_over ? COMMIT : SCAN;
      SCAN: begin
        // Row 0 is the last source; any clear so far means the top needs zero fill.
        if (src == '0) state_nxt = (cnt != '0 || src_full) ? FILL : COMMIT;
      end
      FILL:   if (dst == '0) state_nxt = COMMIT;
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage: published outputs (board only moves in COMMIT)
  always_ff @(posedge clk) begin
    if (reset) begin
      board         <= '0;
      collide       <= 1'b0;
      last_clear    <= '0;
      lines_cleared <= '0;
      game_over     <= 1'b0;
    end else begin
      collide <= |(piece_mask & board);
      if (state == IDLE && accept) game_over <= overlap;
      if (state == COMMIT) begin
        for (int r = 0; r < ROWS; r++) board[row_msb(r, ROWS, COLS) -: COLS] <= work[r];
        last_clear    <= cnt;
        lines_cleared <= sat_add(lines_cleared, cnt);
`ifdef BOARD_TOPOUT_EN
        if (|work[0]) game_over <= 1'b1;
`endif
      end
    end
  end

  // Stage: scratch board and compaction pointers (discarded on reset)
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept) begin
          for (int r = 0; r < ROWS; r++)
            work[r] <= board[row_msb(r, ROWS, COLS) -: COLS]
                     | piece_mask[row_msb(r, ROWS, COLS) -: COLS];
        end
      end
      MERGE: begin
        src <= TOP_IDX;
        dst <= TOP_IDX;
        cnt <= '0;
      end
      SCAN: begin
        src <= src - ONE_IDX;
        if (src_full) begin
          cnt <= cnt + 5'd1;
        end else begin
          work[dst[IDX_W-1:0]] <= src_row;
          dst <= dst - ONE_IDX;
        end
      end
      FILL: begin
        work[dst[IDX_W-1:0]] <= '0;
        dst <= dst - ONE_IDX;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tetris_board_writer.sv
// Scoreboard bench for tetris_board_writer: queue-based row-compaction reference model.
module tb_tetris_board_writer;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int LW   = 8;
  localparam int N    = ROWS * COLS;
  localparam int LMAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          lock_valid = 1'b0;
  logic [N-1:0]  piece_mask = '0;
  logic          lock_ready;
  logic [N-1:0]  board;
  logic          collide;
  logic          busy;
  logic [4:0]    last_clear;
  logic [LW-1:0] lines_cleared;
  logic          game_over;

  tetris_board_writer #(.ROWS(ROWS), .COLS(COLS), .LINES_W(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .piece_mask    (piece_mask),
    .lock_valid    (lock_valid),
    .lock_ready    (lock_ready),
    .board         (board),
    .collide       (collide),
    .busy          (busy),
    .last_clear    (last_clear),
    .lines_cleared (lines_cleared),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] brd;
    int           clr;
    int           lines;
    bit           go;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [N-1:0] m_board  = '0;
  int           m_lines  = 0;
  bit           m_go     = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [COLS-1:0] get_row(input logic [N-1:0] b, input int r);
    return b[N-1-COLS*r -: COLS];
  endfunction

  function automatic logic [N-1:0] put_row(input logic [N-1:0] b, input int r,
                                           input logic [COLS-1:0] v);
    logic [N-1:0] t;
    t = b;
    t[N-1-COLS*r -: COLS] = v;
    return t;
  endfunction

  function automatic logic [N-1:0] rand_bits();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Reference: merge, drop every full row, let survivors fall to the bottom in order.
  task automatic model_lock(input logic [N-1:0] m);
    exp_t            e;
    logic [COLS-1:0] keep[$];
    logic [COLS-1:0] row;
    logic [N-1:0]    merged;
    int              cnt;
    merged = m_board | m;
    e.brd  = '0;
    if (|(m_board & m)) begin
      e.brd = merged;
      cnt   = 0;
      e.go  = 1;
      e.lat = 2;
    end else begin
      for (int r = ROWS - 1; r >= 0; r--) begin
        row = get_row(merged, r);
        if (row != {COLS{1'b1}}) keep.push_back(row);
      end
      cnt = ROWS - keep.size();
      foreach (keep[i]) e.brd = put_row(e.brd, ROWS - 1 - i, keep[i]);
      e.go  = 0;
      e.lat = 22 + cnt;
    end
`ifdef BOARD_TOPOUT_EN
    if (get_row(e.brd, 0) != '0) e.go = 1;
`endif
    m_lines = (m_lines + cnt > LMAX) ? LMAX : m_lines + cnt;
    e.clr   = cnt;
    e.lines = m_lines;
    m_board = e.brd;
    m_go    = e.go;
    sb.push_back(e);
  endtask

  task automatic do_lock(input logic [N-1:0] m, input int junk_cycles);
    int t;
    @(posedge clk); #1;
    piece_mask = m;
    lock_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!lock_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!lock_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL lock_wait: lock_ready got 0 expected 1");
      lock_valid = 1'b0;
      return;
    end
    model_lock(m);
    @(posedge clk); #1;
    if (junk_cycles > 0) begin
      piece_mask = rand_bits();
      repeat (junk_cycles) @(posedge clk);
      #1;
    end
    lock_valid = 1'b0;
    piece_mask = rand_bits() & rand_bits() & rand_bits();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: pending got %0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1;
    reset      = 1'b1;
    lock_valid = 1'b0;
    sb.delete();
    m_board = '0;
    m_lines = 0;
    m_go    = 0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_board", board, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_lock_ready", lock_ready, 1'b1);
    chk("rst_last_clear", last_clear, '0);
    chk("rst_lines", lines_cleared, '0);
    chk("rst_game_over", game_over, 1'b0);
  endtask

  task automatic clear_rows(input int k);
    logic [N-1:0] m;
    m = '0;
    for (int r = ROWS - k; r < ROWS; r++) m = put_row(m, r, ~get_row(m_board, r));
    do_lock(m, 0);
    drain();
  endtask

  // Monitor: collide one cycle behind its inputs; board frozen while busy; pop on busy fall.
  logic [N-1:0] mon_board = '0;
  bit           prev_busy = 0;
  int           cyc       = 0;
  bit           col_vld   = 0;
  logic         col_exp   = 1'b0;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (col_vld) chk("collide", collide, col_exp);
    col_exp = reset ? 1'b0 : |(piece_mask & board);
    col_vld = 1;
    if (reset) begin
      prev_busy = 0;
      cyc       = 0;
      mon_board = '0;
    end else begin
      if (busy) begin
        cyc++;
        chk("board_hold", board, mon_board);
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit: got a commit expected none");
        end else begin
          mon_e = sb.pop_front();
          chk("board", board, mon_e.brd);
          chk("last_clear", last_clear, mon_e.clr);
          chk("lines_cleared", lines_cleared, mon_e.lines);
          chk("game_over", game_over, mon_e.go);
          chk("latency", cyc, mon_e.lat);
          mon_board = mon_e.brd;
        end
        cyc = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] m;
    int           sel;
    int           r;
    bit           exp_go;

    apply_reset(3);

    // T-piece on the floor, no clear.
    m = '0;
    m = put_row(m, 18, 10'b0000100000);
    m = put_row(m, 19, 10'b0001110000);
    do_lock(m, 3);
    drain();

    // Rows 16-18 full except column 0, then a vertical I in column 0.
    m = '0;
    for (int i = 16; i <= 18; i++) m = put_row(m, i, ~get_row(m_board, i) & 10'b0111111111);
    do_lock(m, 0);
    drain();
    m = '0;
    for (int i = 16; i <= 19; i++) m = put_row(m, i, 10'b1000000000);
    do_lock(m, 2);
    drain();
    chk("i_row19", get_row(board, 19), 10'b1001110000);
    chk("i_rows0_2", {get_row(board, 0), get_row(board, 1), get_row(board, 2)}, '0);

    // Non-adjacent clears at rows 17 and 19.
    m = '0;
    m = put_row(m, 17, ~get_row(m_board, 17));
    m = put_row(m, 19, ~get_row(m_board, 19));
    m = put_row(m, 18, 10'b0000000001);
    do_lock(m, 0);
    drain();
    chk("gap_row19", get_row(board, 19), 10'b0000000001);
    chk("gap_clear", last_clear, 5'd2);

    // Random locks confined to rows 5-19, never overlapping the board.
    for (int n = 0; n < 40; n++) begin
      m = '0;
      for (int i = 5; i < ROWS; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 2)      m = put_row(m, i, ~get_row(m_board, i));
        else if (sel < 4) m = put_row(m, i, COLS'($urandom) & ~get_row(m_board, i));
      end
      do_lock(m, $urandom_range(0, 4));
    end
    drain();

    // Drive the counter to 254, then saturate.
    while (m_lines + 15 <= LMAX - 1) clear_rows(15);
    r = LMAX - 1 - m_lines;
    if (r > 0) clear_rows(r);
    clear_rows(4);
    chk("sat_lines", lines_cleared, LMAX);
    clear_rows(2);

    // Reset while the FSM is scanning.
    m = '0;
    m = put_row(m, 19, ~get_row(m_board, 19) & 10'b0111111111);
    do_lock(m, 0);
    repeat (4) @(posedge clk);
    apply_reset(1);

    // Overlapping lock ends the game; later requests are ignored.
    m = put_row('0, 19, 10'b1100000000);
    do_lock(m, 0);
    drain();
    m = '0;
    m = put_row(m, 19, 10'b1000000000);
    m = put_row(m, 18, 10'b0000000011);
    do_lock(m, 0);
    drain();
    chk("go_flag", game_over, 1'b1);
    chk("go_lock_ready", lock_ready, 1'b0);
    @(posedge clk); #1;
    lock_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      piece_mask = rand_bits();
      @(negedge clk);
      chk("go_busy", busy, 1'b0);
      @(posedge clk); #1;
    end
    lock_valid = 1'b0;
    @(negedge clk);
    chk("go_board_frozen", board, m_board);
    chk("go_sticky", game_over, 1'b1);

    // A cell left in the top row.
    apply_reset(2);
    m = '0;
    m = put_row(m, 0, 10'b0000010000);
    m = put_row(m, 19, 10'b0000000110);
    do_lock(m, 0);
    drain();
`ifdef BOARD_TOPOUT_EN
    exp_go = 1;
`else
    exp_go = 0;
`endif
    chk("topout_game_over", game_over, exp_go);
    chk("topout_lock_ready", lock_ready, !exp_go);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
